// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency MEM-stage data RAM responder with stall request
// Optional misaligned-access check: define DMEM_ALIGN_CHK_EN.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        stall,
  output logic        addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] LAT_CNT = 3'(LATENCY);

  if (LATENCY < 0 || LATENCY > 7) begin : gBadLatency
    $fatal(1, "data_mem_responder: LATENCY must be within 0..7");
  end

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        latWe;
  logic [3:0]  latWstrb;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [31:0] mem [0:DEPTH-1];

  logic                  finishNow;
  logic                  opWe;
  logic [3:0]            opWstrb;
  logic [31:0]           opAddr;
  logic [31:0]           opWdata;
  logic                  opMis;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unusedBits;

  // With zero latency the access completes on the accepting edge, so it must use the live inputs.
  always_comb begin
    opWe    = latWe;
    opWstrb = latWstrb;
    opAddr  = latAddr;
    opWdata = latWdata;
    if (state == IDLE) begin
      opWe    = req_we;
      opWstrb = req_wstrb;
      opAddr  = req_addr;
      opWdata = req_wdata;
    end
  end

  assign finishNow  = ((state == IDLE) && req_en && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == 3'd1));
  assign idx        = opAddr[DEPTH_LOG2+1:2];
  assign unusedBits = ^{opAddr[31:DEPTH_LOG2+2], opAddr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
  assign opMis    = (opAddr[1:0] != 2'b00);
  assign addr_err = (state == DONE) && (latAddr[1:0] != 2'b00);
`else
  assign opMis    = 1'b0;
  assign addr_err = 1'b0;
`endif

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req_en;
      WAIT:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign resp_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      rdata    <= 32'd0;
      latWe    <= 1'b0;
      latWstrb <= 4'd0;
      latAddr  <= 32'd0;
      latWdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_en) begin
            latWe    <= req_we;
            latWstrb <= req_wstrb;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
            cnt      <= LAT_CNT;
            state    <= (LATENCY == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= DONE;
        end
        // The request still held in DONE is the instruction just serviced, never a new one.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finishNow && !opWe) rdata <= opMis ? 32'd0 : mem[idx];
    end
  end

  // RAM is not reset; the rst term keeps a zero-latency store from landing during reset.
  always_ff @(posedge clk) begin
    if (finishNow && opWe && !opMis && rst) begin
      for (int i = 0; i < 4; i++) begin
        if (opWstrb[i]) mem[idx][8*i +: 8] <= opWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=0 instances)
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DLOG  = 10;
  localparam int DEPTH = 1 << DLOG;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqEn, reqWe;
  logic [3:0]  reqWstrb;
  logic [31:0] reqAddr, reqWdata;
  logic [31:0] rdata;
  logic        respValid, stall, addrErr;

  logic        zEn, zWe;
  logic [3:0]  zStrb;
  logic [31:0] zAddr, zWdata;
  logic [31:0] zRdata;
  logic        zResp, zStall, zErr;

  int          total = 0;
  int          bad = 0;
  exp_t        expQ[$];
  exp_t        monE;
  logic [31:0] modelMem [DEPTH];
  logic [31:0] modelRdata;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(DLOG), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_en(reqEn), .req_we(reqWe), .req_wstrb(reqWstrb),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rdata(rdata), .resp_valid(respValid),
    .stall(stall), .addr_err(addrErr)
  );

  data_mem_responder #(.DEPTH_LOG2(DLOG), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_en(zEn), .req_we(zWe), .req_wstrb(zStrb),
    .req_addr(zAddr), .req_wdata(zWdata), .rdata(zRdata), .resp_valid(zResp),
    .stall(zStall), .addr_err(zErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: word index is the byte address divided by four, modulo RAM depth.
  task automatic doTxn(input bit we, input logic [3:0] ws, input logic [31:0] a, input logic [31:0] d);
    int   idx;
    int   cyc;
    bit   seen;
    bit   stallOk;
    bit   mis;
    exp_t e;
    idx = int'((a / 4) % DEPTH);
    mis = misaligned(a);
    if (we) begin
      if (!mis)
        for (int b = 0; b < 4; b++)
          if (ws[b]) modelMem[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      modelRdata = mis ? 32'd0 : modelMem[idx];
    end
    e.data = modelRdata;
    e.err  = mis;
    expQ.push_back(e);

    @(negedge clk);
    reqEn = 1'b1; reqWe = we; reqWstrb = ws; reqAddr = a; reqWdata = d;
    #1;
    stallOk = (stall === 1'b1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (respValid === 1'b1) begin
        seen = 1'b1;
        if (stall !== 1'b0) stallOk = 1'b0;
      end else if (stall !== 1'b1) begin
        stallOk = 1'b0;
      end
    end
    check("latency", 32'(cyc), 32'(LAT + 1));
    check("stall_window", {31'd0, stallOk}, 32'd1);
    @(posedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && respValid === 1'b1) begin
        if (expQ.size() == 0) begin
          check("spurious_resp", {31'd0, respValid}, 32'd0);
        end else begin
          monE = expQ.pop_front();
          check("rdata", rdata, monE.data);
          check("addr_err", {31'd0, addrErr}, {31'd0, monE.err});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prior;
    int          pulses;
    int          idx;
    logic [31:0] a;

    rst = 1'b0;
    reqEn = 0; reqWe = 0; reqWstrb = 0; reqAddr = 0; reqWdata = 0;
    zEn = 0; zWe = 0; zStrb = 0; zAddr = 0; zWdata = 0;
    modelRdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {31'd0, respValid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_addr_err", {31'd0, addrErr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 32; i++) doTxn(1'b1, 4'hF, 32'(i * 4), $urandom);

    doTxn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    doTxn(1'b0, 4'h0, 32'h10, 32'h0);
    #1 check("store_load", rdata, 32'hDEADBEEF);

    doTxn(1'b1, 4'hF, 32'h20, 32'h11223344);
    doTxn(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    doTxn(1'b0, 4'h0, 32'h20, 32'h0);
    #1 check("byte_lanes", rdata, 32'h11BB33DD);

    doTxn(1'b1, 4'hF, 32'h0000_1004, 32'h5);
    doTxn(1'b0, 4'h0, 32'h0000_0004, 32'h0);
    #1 check("alias", rdata, 32'h5);

    doTxn(1'b1, 4'hF, 32'h40, 32'h12345678);
    doTxn(1'b1, 4'hF, 32'h42, 32'hFFFF0000);
    doTxn(1'b0, 4'h0, 32'h40, 32'h0);
`ifdef DMEM_ALIGN_CHK_EN
    #1 check("misaligned_store", rdata, 32'h12345678);
`else
    #1 check("misaligned_store", rdata, 32'hFFFF0000);
`endif

    doTxn(1'b1, 4'h0, 32'h44, 32'hFFFFFFFF);
    doTxn(1'b0, 4'h0, 32'h44, 32'h0);

    // Reset while a store is waiting: it must be discarded.
    prior = modelMem[12];
    @(negedge clk);
    reqEn = 1'b1; reqWe = 1'b1; reqWstrb = 4'hF; reqAddr = 32'h30; reqWdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reqEn = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_resp", {31'd0, respValid}, 32'd0);
    modelRdata = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    doTxn(1'b0, 4'h0, 32'h30, 32'h0);
    #1 check("midrst_discard", rdata, prior);

    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 31);
      a = ($urandom & 32'hFFFF_F000) | 32'(idx * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      doTxn(1'($urandom), 4'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        reqEn = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
    @(negedge clk);
    reqEn = 1'b0;
    repeat (4) @(posedge clk);
    check("queue_drained", 32'(expQ.size()), 32'd0);

    // Zero-latency instance: request held through DONE must yield exactly one response.
    @(negedge clk);
    zEn = 1'b1; zWe = 1'b1; zStrb = 4'hF; zAddr = 32'h8; zWdata = 32'hCAFE0001;
    #1 check("z_stall_c0", {31'd0, zStall}, 32'd1);
    @(posedge clk);
    #1;
    check("z_resp_c1", {31'd0, zResp}, 32'd1);
    check("z_stall_c1", {31'd0, zStall}, 32'd0);
    @(posedge clk);
    #1 check("z_no_reaccept", {31'd0, zResp}, 32'd0);
    @(negedge clk);
    zEn = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (zResp === 1'b1) pulses++;
    end
    check("z_idle_pulses", 32'(pulses), 32'd0);

    @(negedge clk);
    zEn = 1'b1; zWe = 1'b0; zAddr = 32'h8;
    #1 check("z_load_stall", {31'd0, zStall}, 32'd1);
    @(posedge clk);
    #1;
    check("z_load_resp", {31'd0, zResp}, 32'd1);
    check("z_load_rdata", zRdata, 32'hCAFE0001);
    @(posedge clk);
    #1 check("z_load_single", {31'd0, zResp}, 32'd0);
    @(negedge clk);
    zEn = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
